// File: rtl/psimd_pkg.sv
//------------------------------------------------------------------------------
// psimd_pkg
// Shared types and constants for the PSIMD lane sequencer and its lane
// operand selector.
//   psimd_mode_t : operation flavour, DLFloat16 (three operand registers,
//                  four 16-bit lanes) or INT32 (two registers, four 32-bit
//                  lanes).
//   seq_state_t  : sequencer control states.
//   LANES, FP_W, INT_W, REG_W : lane count and lane/register widths.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

package psimd_pkg;

   localparam int LANES = 4;
   localparam int FP_W  = 16;
   localparam int INT_W = 32;
   localparam int REG_W = 64;

   typedef enum logic {
      MODE_FP16  = 1'b0,
      MODE_INT32 = 1'b1
   } psimd_mode_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } seq_state_t;

endpackage

// File: rtl/psimd_lane_select.sv
//------------------------------------------------------------------------------
// psimd_lane_select
// Purely combinational extraction of one lane's operands from the captured
// operand registers.
//   data1/2/3      : FP16 operand registers, lane k at [16k+15:16k]
//   datai_0/1      : INT32 operand registers, lanes 0/1 in datai_0 and
//                    lanes 2/3 in datai_1 (low word first)
//   idx            : lane being selected
//   a, b, c        : FP16 operands of lane idx
//   int_op         : INT32 operand of lane idx
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module psimd_lane_select
   import psimd_pkg::*;
(
   input  logic [REG_W-1:0] data1,
   input  logic [REG_W-1:0] data2,
   input  logic [REG_W-1:0] data3,
   input  logic [REG_W-1:0] datai_0,
   input  logic [REG_W-1:0] datai_1,
   input  logic [1:0]       idx,
   output logic [FP_W-1:0]  a,
   output logic [FP_W-1:0]  b,
   output logic [FP_W-1:0]  c,
   output logic [INT_W-1:0] int_op
);

   logic [5:0]       fp_off;
   logic [REG_W-1:0] int_word;

   // FP16 lanes sit at a 16-bit stride, so the bit offset is just the lane
   // index shifted up by four. INT32 lanes first pick the register by the
   // upper index bit, then the half-word by the lower bit.
   always_comb begin
      fp_off   = {idx, 4'b0000};
      a        = data1[fp_off +: FP_W];
      b        = data2[fp_off +: FP_W];
      c        = data3[fp_off +: FP_W];
      int_word = idx[1] ? datai_1 : datai_0;
      int_op   = idx[0] ? int_word[63:32] : int_word[31:0];
   end

endmodule

// File: rtl/psimd_lane_sequencer.sv
//------------------------------------------------------------------------------
// psimd_lane_sequencer
// Accepts one packed PSIMD operation, issues its four lanes one per cycle to
// a single shared lane execution unit, gathers the (possibly out-of-order)
// lane results and presents them repacked as 64-bit result registers.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : operation handshake
//   in_mode              : 0 = DLFloat16 (in_data1/2/3), 1 = INT32 (in_datai_0/1)
//   in_data1/2/3         : FP16 operand registers
//   in_datai_0/1         : INT32 operand registers
//   lane_valid/ready     : lane issue handshake to the shared unit
//   lane_idx, lane_mode  : lane being issued and its mode
//   lane_a/b/c, lane_int : lane operands
//   lane_res_*           : lane result return (no backpressure)
//   out_valid/out_ready  : packed result handshake
//   out_mode             : mode of the packed result
//   out_data             : packed FP16 result (zero in INT32 mode)
//   out_datai_0/1        : packed INT32 results (zero in FP16 mode)
//   seq_err              : sticky protocol error flag, cleared only by reset
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module psimd_lane_sequencer
   import psimd_pkg::*;
#(
   parameter int REG_WIDTH = 64,
   parameter int NUM_LANES = 4
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_mode,
   input  logic [REG_WIDTH-1:0] in_data1,
   input  logic [REG_WIDTH-1:0] in_data2,
   input  logic [REG_WIDTH-1:0] in_data3,
   input  logic [REG_WIDTH-1:0] in_datai_0,
   input  logic [REG_WIDTH-1:0] in_datai_1,
   output logic                 lane_valid,
   input  logic                 lane_ready,
   output logic [1:0]           lane_idx,
   output logic                 lane_mode,
   output logic [FP_W-1:0]      lane_a,
   output logic [FP_W-1:0]      lane_b,
   output logic [FP_W-1:0]      lane_c,
   output logic [INT_W-1:0]     lane_int,
   input  logic                 lane_res_valid,
   input  logic [1:0]           lane_res_idx,
   input  logic [FP_W-1:0]      lane_res_fp,
   input  logic [INT_W-1:0]     lane_res_int,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_mode,
   output logic [REG_WIDTH-1:0] out_data,
   output logic [REG_WIDTH-1:0] out_datai_0,
   output logic [REG_WIDTH-1:0] out_datai_1,
   output logic                 seq_err
);

   seq_state_t           state;
   psimd_mode_t          mode_r;
   logic [REG_WIDTH-1:0] data1_r;
   logic [REG_WIDTH-1:0] data2_r;
   logic [REG_WIDTH-1:0] data3_r;
   logic [REG_WIDTH-1:0] datai0_r;
   logic [REG_WIDTH-1:0] datai1_r;
   logic [2:0]           issue_cnt;
   logic [2:0]           ret_cnt;
   logic [2:0]           ret_cnt_nxt;
   logic [NUM_LANES-1:0] res_mask;
   logic [FP_W-1:0]      res_fp  [NUM_LANES];
   logic [INT_W-1:0]     res_int [NUM_LANES];
   logic                 res_window;
   logic                 res_issued;
   logic                 res_dup;
   logic                 res_accept;
   logic                 res_error;

   // Handshake and lane-control outputs are straight decodes of the state
   // and counter registers, so they never depend combinationally on inputs.
   assign in_ready   = (state == S_IDLE);
   assign lane_valid = (state == S_ISSUE);
   assign out_valid  = (state == S_DONE);
   assign lane_idx   = issue_cnt[1:0];
   assign lane_mode  = mode_r;
   assign out_mode   = mode_r;

   // The lane operands are the slices of the captured registers picked by
   // the current issue index; they stay put while the unit stalls because
   // issue_cnt only moves on an accepted issue.
   psimd_lane_select u_lane_select (
      .data1   (data1_r),
      .data2   (data2_r),
      .data3   (data3_r),
      .datai_0 (datai0_r),
      .datai_1 (datai1_r),
      .idx     (issue_cnt[1:0]),
      .a       (lane_a),
      .b       (lane_b),
      .c       (lane_c),
      .int_op  (lane_int)
   );

   // Classify a returning lane result. Only results that arrive while lanes
   // are in flight, for a lane that has really been issued, and for a slot
   // not yet filled are accepted; anything else is a protocol error and is
   // dropped. The next return count is exposed so the drain state can move
   // to DONE on the same edge that stores the final result.
   always_comb begin
      res_window  = (state == S_ISSUE) || (state == S_DRAIN);
      res_issued  = ({1'b0, lane_res_idx} < issue_cnt);
      res_dup     = res_mask[lane_res_idx];
      res_accept  = lane_res_valid && res_window && res_issued && !res_dup;
      res_error   = lane_res_valid && !res_accept;
      ret_cnt_nxt = ret_cnt + {2'b00, res_accept};
   end

   // Repack the result slots into register form. The lane placement mirrors
   // the operand layout, and the register set that does not belong to the
   // current mode is forced to zero.
   always_comb begin
      out_data    = '0;
      out_datai_0 = '0;
      out_datai_1 = '0;
      if (mode_r == MODE_FP16) begin
         out_data = {res_fp[3], res_fp[2], res_fp[1], res_fp[0]};
      end else begin
         out_datai_0 = {res_int[1], res_int[0]};
         out_datai_1 = {res_int[3], res_int[2]};
      end
   end

   // Main sequencer. IDLE captures an operation and clears the bookkeeping,
   // ISSUE walks the lane index forward on every accepted issue, DRAIN waits
   // for the fourth distinct result, and DONE holds the packed result until
   // the consumer takes it. Result capture runs alongside the state machine
   // because results may already come back while later lanes are issuing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         mode_r    <= MODE_FP16;
         data1_r   <= '0;
         data2_r   <= '0;
         data3_r   <= '0;
         datai0_r  <= '0;
         datai1_r  <= '0;
         issue_cnt <= '0;
         ret_cnt   <= '0;
         res_mask  <= '0;
         seq_err   <= 1'b0;
         for (int k = 0; k < NUM_LANES; k++) begin
            res_fp[k]  <= '0;
            res_int[k] <= '0;
         end
      end else begin
         if (res_error) begin
            seq_err <= 1'b1;
         end

         if (res_accept) begin
            res_mask[lane_res_idx] <= 1'b1;
            ret_cnt                <= ret_cnt_nxt;
            if (mode_r == MODE_FP16) begin
               res_fp[lane_res_idx] <= lane_res_fp;
            end else begin
               res_int[lane_res_idx] <= lane_res_int;
            end
         end

         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  mode_r    <= psimd_mode_t'(in_mode);
                  data1_r   <= in_data1;
                  data2_r   <= in_data2;
                  data3_r   <= in_data3;
                  datai0_r  <= in_datai_0;
                  datai1_r  <= in_datai_1;
                  issue_cnt <= '0;
                  ret_cnt   <= '0;
                  res_mask  <= '0;
                  for (int k = 0; k < NUM_LANES; k++) begin
                     res_fp[k]  <= '0;
                     res_int[k] <= '0;
                  end
                  state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (lane_ready) begin
                  issue_cnt <= issue_cnt + 3'd1;
                  if (issue_cnt == 3'd3) begin
                     state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (ret_cnt_nxt == 3'd4) begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/psimd_lane_sequencer.md
Name: psimd_lane_sequencer

Overview:
- Accepts one packed PSIMD operation per handshake:
  - DLFloat16 mode: three 64-bit operand registers, four 16-bit lanes each.
  - INT32 mode: two 64-bit registers, four 32-bit lanes total.
- Time-multiplexes the four lanes onto a single shared lane execution unit, one lane per cycle.
- Collects the lane results and repacks them into 64-bit result registers.
- Sits between the PSIMD register read stage and writeback; replaces four parallel lane units with one shared unit.

Parameters:
- REG_WIDTH, 64, packed register width; only 64 is supported (4 lanes × 16b FP, 4 lanes × 32b INT).
- NUM_LANES, 4, lanes per operation; fixed at 4.

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation request valid
- in_ready  out  1  sequencer can accept an operation
- in_mode  in  1  0 = DLFloat16 (data1/2/3), 1 = INT32 (datai_0/1)
- in_data1, in_data2, in_data3  in  64 each  FP16 operand registers; lane k = bits [16k+15:16k]
- in_datai_0, in_datai_1  in  64 each  INT32 operands; lanes 0,1 in datai_0 [31:0],[63:32]; lanes 2,3 in datai_1
- lane_valid  out  1  lane issue valid
- lane_ready  in  1  lane unit accepts issue
- lane_idx  out  2  lane index being issued
- lane_mode  out  1  registered mode
- lane_a, lane_b, lane_c  out  16 each  FP16 lane operands
- lane_int  out  32  INT32 lane operand
- lane_res_valid  in  1  lane result valid (unit has no backpressure)
- lane_res_idx  in  2  index of returned result
- lane_res_fp  in  16  FP16 result
- lane_res_int  in  32  INT32 result
- out_valid  out  1  packed result valid
- out_ready  in  1  consumer accepts result
- out_mode  out  1  mode of the result
- out_data  out  64  packed FP16 result; lane k at [16k+15:16k]
- out_datai_0, out_datai_1  out  64 each  packed INT32 results, same lane placement as inputs
- seq_err  out  1  sticky protocol error flag

Behaviour:
- Reset (async, rst_n = 0):
  - FSM to IDLE.
  - in_ready = 1; lane_valid = 0; out_valid = 0; seq_err = 0.
  - All data outputs, operand and result registers, and counters = 0.
- FSM states:
  - IDLE:
    - in_ready = 1.
    - On in_valid: capture all operands and mode; issue_cnt = 0, ret_cnt = 0, res_mask = 0; go to ISSUE.
  - ISSUE:
    - lane_valid = 1, lane_idx = issue_cnt; operands are the lane-indexed slices of the captured registers.
    - On lane_valid & lane_ready: issue_cnt increments.
    - After lane 3 is accepted, lane_valid drops the next cycle; go to DRAIN.
    - lane_valid/idx/operands stay stable while lane_ready = 0.
  - DRAIN:
    - Wait for ret_cnt == 4, then go to DONE.
    - Results may already arrive during ISSUE; ret_cnt and res_mask are updated in both ISSUE and DRAIN.
  - DONE:
    - out_valid = 1; outputs are stable until out_ready.
    - On out_valid & out_ready: go to IDLE, in_ready = 1 the next cycle.
- Result capture:
  - On lane_res_valid, write lane_res_fp or lane_res_int into slot lane_res_idx.
  - Set res_mask[idx]; ret_cnt increments.
  - Results may return out of order.
- Error cases: seq_err is set and stays set until reset.
  - Duplicate index (res_mask[idx] already set): data is not overwritten.
  - lane_res_valid in IDLE or DONE: ignored.
  - lane_res_idx ≥ issue_cnt (result for an unissued lane): ignored.
- Output data by mode:
  - FP16 mode: out_datai_* = 0.
  - INT32 mode: out_data = 0.
- Latency:
  - Accept at cycle T; with lane_ready = 1, issues occur at T+1 to T+4.
  - With a 1-cycle lane unit, the last result arrives at T+5 and out_valid rises at T+6.
- Throughput: one operation in flight; no overlap between the DONE and IDLE accept.
- Reset mid-operation: returns to IDLE immediately; any partial result is discarded.

Decomposition:
- psimd_pkg:
  - typedef enum logic {MODE_FP16, MODE_INT32} psimd_mode_t.
  - typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} seq_state_t.
  - Constants: LANES = 4, FP_W = 16, INT_W = 32.
- Sub-module psimd_lane_select: combinational extraction of lane k operands (FP16 slices and INT32 from datai_0/1) by lane_idx.

Test Plan:
1. FP16, lane_ready = 1, 1-cycle echo unit (result = lane_a):
   - Stimulus: data1 = 0x4444_3333_2222_1111.
   - Required: lane_idx 0,1,2,3 on consecutive cycles; out_data = 0x4444_3333_2222_1111 at T+6; out_datai_* = 0.
2. INT32 with out-of-order returns (idx order 2,0,3,1):
   - Stimulus: datai_0 = 0x0000_0002_0000_0001, datai_1 = 0x0000_0004_0000_0003, echo unit.
   - Required: outputs equal inputs; seq_err = 0.
3. lane_ready stall: hold lane_ready = 0 for 3 cycles on lane 2.
   - Required: lane_idx = 2 and operands stable during the stall; exactly 4 issues total.
4. Backpressure: out_ready = 0 for 5 cycles in DONE.
   - Required: out_valid and data stable; in_ready = 0 throughout; IDLE one cycle after out_ready.
5. Errors:
   - Duplicate idx 1 carrying 0xFFFF: seq_err = 1 and the lane 1 slot keeps its first value.
   - Stray lane_res_valid in IDLE: seq_err = 1.
6. Reset mid-DRAIN:
   - Assert rst_n = 0 after 2 results.
   - Required: all outputs zero immediately; in_ready = 1 after release; a fresh operation completes correctly.
